// File: rtl/frame_buffer_dual_if.sv
// Writer-side port of the ping-pong frame buffer: pixel writes, commit and clear requests.
// Signals: wr_valid/wr_ready handshake, wr_addr/wr_data, wr_commit pulse, clear_req pulse with clear_data.
// master = writer (pattern generator / UART loader), slave = frame_buffer_dual.
interface frame_buffer_dual_if #(
    parameter int ADDR_WIDTH  = 8,
    parameter int COLOR_DEPTH = 8
);
    logic                   wr_valid;
    logic                   wr_ready;
    logic [ADDR_WIDTH-1:0]  wr_addr;
    logic [COLOR_DEPTH-1:0] wr_data;
    logic                   wr_commit;
    logic                   clear_req;
    logic [COLOR_DEPTH-1:0] clear_data;

    modport master (
        output wr_valid, wr_addr, wr_data, wr_commit, clear_req, clear_data,
        input  wr_ready
    );

    modport slave (
        input  wr_valid, wr_addr, wr_data, wr_commit, clear_req, clear_data,
        output wr_ready
    );
endinterface

// File: rtl/frame_buffer_dual.sv
// Double-buffered (ping-pong) RGB332 pixel store; back bank written by the writer, front bank read by the LED driver.
// Read latency 1 cycle, never stalls; writes accepted in the same cycle while in WRITE.
// wr_ready drops during a hardware clear and while waiting for a frame boundary to swap banks.
// Ports: clk, rst_n (async active-low), read_addr -> pixel_data, pwm_cycle_end/row_counter (frame boundary),
//        wr (writer interface, slave side), busy, swap_done, front_sel.
module frame_buffer_dual #(
    parameter int COLOR_DEPTH = 8,
    parameter int ADDR_WIDTH  = 8,
    parameter int MATRIX_SIZE = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [ADDR_WIDTH-1:0]  read_addr,
    output logic [COLOR_DEPTH-1:0] pixel_data,
    input  logic                   pwm_cycle_end,
    input  logic [3:0]             row_counter,
    frame_buffer_dual_if.slave     wr,
    output logic                   busy,
    output logic                   swap_done,
    output logic                   front_sel
);
    localparam int DEPTH = 1 << ADDR_WIDTH;

    typedef enum logic [1:0] {
        ST_WRITE     = 2'd0,
        ST_CLEAR     = 2'd1,
        ST_SWAP_WAIT = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic                   front_q, front_d;
    logic                   swap_q, swap_d;
    logic                   pend_q, pend_d;
    logic [ADDR_WIDTH-1:0]  cnt_q, cnt_d;
    logic [COLOR_DEPTH-1:0] clr_q, clr_d;
    logic                   live_q;       // low only until the first clock after reset
    logic [COLOR_DEPTH-1:0] pix_q;

    logic                   frame_end;
    logic                   cnt_last;
    logic                   ready;
    logic                   mem_we;
    logic [ADDR_WIDTH-1:0]  mem_wa;
    logic [COLOR_DEPTH-1:0] mem_wd;

    // Both banks in one array; the bank select is the address MSB.
    logic [COLOR_DEPTH-1:0] mem [0:2*DEPTH-1];

    assign frame_end = pwm_cycle_end && (row_counter == 4'(MATRIX_SIZE - 1));
    assign cnt_last  = (cnt_q == {ADDR_WIDTH{1'b1}});

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_WRITE;
            front_q <= 1'b0;
            swap_q  <= 1'b0;
            pend_q  <= 1'b0;
            cnt_q   <= '0;
            clr_q   <= '0;
            live_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            front_q <= front_d;
            swap_q  <= swap_d;
            pend_q  <= pend_d;
            cnt_q   <= cnt_d;
            clr_q   <= clr_d;
            live_q  <= 1'b1;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        front_d = front_q;
        swap_d  = 1'b0;
        pend_d  = pend_q;
        cnt_d   = cnt_q;
        clr_d   = clr_q;
        case (state_q)
            ST_WRITE: begin
                if (wr.clear_req) begin
                    state_d = ST_CLEAR;
                    clr_d   = wr.clear_data;
                    cnt_d   = '0;
                    pend_d  = wr.wr_commit;
                end else if (wr.wr_commit) begin
                    state_d = ST_SWAP_WAIT;
                end
            end
            ST_CLEAR: begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_last) begin
                    // A commit arriving on the final clear cycle still counts.
                    state_d = (pend_q || wr.wr_commit) ? ST_SWAP_WAIT : ST_WRITE;
                    pend_d  = 1'b0;
                end else if (wr.wr_commit) begin
                    pend_d = 1'b1;
                end
            end
            ST_SWAP_WAIT: begin
                // Only boundaries seen while already in this state count, so a
                // frame_end coinciding with the commit cycle is skipped naturally.
                if (frame_end) begin
                    state_d = ST_WRITE;
                    front_d = ~front_q;
                    swap_d  = 1'b1;
                end
            end
            default: state_d = ST_WRITE;
        endcase
    end

    // Output logic
    always_comb begin
        ready  = live_q && (state_q == ST_WRITE);
        busy   = (state_q != ST_WRITE);
        mem_we = 1'b0;
        mem_wa = wr.wr_addr;
        mem_wd = wr.wr_data;
        case (state_q)
            ST_WRITE: mem_we = wr.wr_valid && ready;
            ST_CLEAR: begin
                mem_we = 1'b1;
                mem_wa = cnt_q;
                mem_wd = clr_q;
            end
            default: mem_we = 1'b0;
        endcase
    end

    // Back-bank write port; contents are deliberately not reset.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[{~front_q, mem_wa}] <= mem_wd;
        end
    end

    // Front-bank read port; uses the bank selected before any toggle on this edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pix_q <= '0;
        end else begin
            pix_q <= mem[{front_q, read_addr}];
        end
    end

    assign pixel_data  = pix_q;
    assign wr.wr_ready = ready;
    assign swap_done   = swap_q;
    assign front_sel   = front_q;
endmodule

// File: tb/tb_frame_buffer_dual.sv
module tb_frame_buffer_dual;
    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] read_addr;
    logic [7:0] pixel_data;
    logic       pwm_cycle_end;
    logic [3:0] row_counter;
    logic       busy;
    logic       swap_done;
    logic       front_sel;

    always #5 clk = ~clk;

    frame_buffer_dual_if #(.ADDR_WIDTH(8), .COLOR_DEPTH(8)) wr_if ();

    frame_buffer_dual #(
        .COLOR_DEPTH(8),
        .ADDR_WIDTH (8),
        .MATRIX_SIZE(16)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .read_addr    (read_addr),
        .pixel_data   (pixel_data),
        .pwm_cycle_end(pwm_cycle_end),
        .row_counter  (row_counter),
        .wr           (wr_if),
        .busy         (busy),
        .swap_done    (swap_done),
        .front_sel    (front_sel)
    );

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    endtask

    // Reference model: what the display and writer should see, per the block's rules.
    logic [7:0] m_mem [0:511];
    bit         m_known [0:511];
    int         m_front, m_mode, m_cnt; // mode: 0 accepting writes, 1 clearing, 2 waiting for boundary
    bit         m_pend, m_live, m_swap, m_acc, m_pix_known;
    logic [7:0] m_clr, m_pix;
    bit         rnd_rd, rnd_pwm;

    task automatic model_reset();
        m_front = 0; m_mode = 0; m_cnt = 0; m_pend = 0; m_live = 0;
        m_swap = 0; m_acc = 0; m_pix = 8'h00; m_pix_known = 1;
    endtask

    task automatic model_update();
        bit fe, rdy;
        int back;
        fe   = pwm_cycle_end && (row_counter == 4'd15);
        rdy  = m_live && (m_mode == 0);
        back = (1 - m_front) * 256;
        m_pix       = m_mem[m_front*256 + int'(read_addr)];
        m_pix_known = m_known[m_front*256 + int'(read_addr)];
        m_swap = 0;
        m_acc  = 0;
        case (m_mode)
            0: begin
                if (wr_if.wr_valid && rdy) begin
                    m_mem[back + int'(wr_if.wr_addr)]   = wr_if.wr_data;
                    m_known[back + int'(wr_if.wr_addr)] = 1;
                    m_acc = 1;
                end
                if (wr_if.clear_req) begin
                    m_mode = 1; m_clr = wr_if.clear_data; m_cnt = 0; m_pend = wr_if.wr_commit;
                end else if (wr_if.wr_commit) begin
                    m_mode = 2;
                end
            end
            1: begin
                m_mem[back + m_cnt]   = m_clr;
                m_known[back + m_cnt] = 1;
                if (wr_if.wr_commit) m_pend = 1;
                if (m_cnt == 255) begin
                    m_mode = m_pend ? 2 : 0;
                    m_pend = 0;
                end
                m_cnt++;
            end
            default: begin
                if (fe) begin
                    m_front = 1 - m_front;
                    m_swap  = 1;
                    m_mode  = 0;
                end
            end
        endcase
        m_live = 1;
    endtask

    task automatic check_all();
        chk("wr_ready", wr_if.wr_ready, (m_live && m_mode == 0));
        chk("busy", busy, (m_mode != 0));
        chk("swap_done", swap_done, m_swap);
        chk("front_sel", front_sel, m_front[0]);
        if (m_pix_known) chk("pixel_data", pixel_data, m_pix);
    endtask

    task automatic cyc();
        if (rnd_rd) read_addr = 8'($urandom);
        if (rnd_pwm) begin
            pwm_cycle_end = ($urandom_range(0, 5) == 0);
            row_counter   = ($urandom_range(0, 1) == 1) ? 4'd15 : 4'($urandom);
        end
        @(posedge clk);
        model_update();
        #1;
        check_all();
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) cyc();
    endtask

    task automatic pulse_commit();
        wr_if.wr_commit = 1'b1; cyc(); wr_if.wr_commit = 1'b0;
    endtask

    task automatic pulse_clear(input logic [7:0] d);
        wr_if.clear_req = 1'b1; wr_if.clear_data = d; cyc();
        wr_if.clear_req = 1'b0; wr_if.clear_data = 8'($urandom);
    endtask

    task automatic write_px(input logic [7:0] a, input logic [7:0] d, output int waited);
        bit done = 0;
        waited = 0;
        wr_if.wr_valid = 1'b1; wr_if.wr_addr = a; wr_if.wr_data = d;
        for (int k = 0; k < 2000 && !done; k++) begin
            cyc();
            waited++;
            if (m_acc) done = 1;
        end
        wr_if.wr_valid = 1'b0;
        if (!done) chk("write_timeout", 0, 1);
    endtask

    task automatic wait_swap(input int budget);
        bit done = 0;
        rnd_pwm = 0;
        row_counter = 4'd15;
        for (int k = 0; k < budget && !done; k++) begin
            pwm_cycle_end = (k % 4 == 3);
            cyc();
            if (m_swap) begin
                done = 1;
                chk("swap_pulse", swap_done, 1);
            end
        end
        pwm_cycle_end = 1'b0;
        if (!done) chk("swap_timeout", 0, 1);
    endtask

    task automatic read_chk(input string tag, input logic [7:0] a, input logic [7:0] exp);
        read_addr = a;
        cyc();
        chk(tag, pixel_data, exp);
    endtask

    initial begin
        int w;
        logic [7:0] cd;
        for (int i = 0; i < 512; i++) m_known[i] = 0;
        rnd_rd = 1; rnd_pwm = 0;
        rst_n = 1'b0; read_addr = 8'h00; pwm_cycle_end = 1'b0; row_counter = 4'd0;
        wr_if.wr_valid = 1'b0; wr_if.wr_addr = 8'h00; wr_if.wr_data = 8'h00;
        wr_if.wr_commit = 1'b0; wr_if.clear_req = 1'b0; wr_if.clear_data = 8'h00;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_pixel", pixel_data, 8'h00);
        chk("rst_ready", wr_if.wr_ready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_swap", swap_done, 0);
        chk("rst_front", front_sel, 0);
        @(negedge clk);
        rst_n = 1'b1;
        cyc();
        chk("ready_after_rst", wr_if.wr_ready, 1);

        // 1: clear to black, commit, swap; then one pixel into bank 0 and swap back.
        pulse_clear(8'h00);
        pulse_commit();
        wait_swap(400);
        chk("t1_front1", front_sel, 1);
        write_px(8'h23, 8'hE0, w);
        pulse_commit();
        wait_swap(40);
        chk("t1_front0", front_sel, 0);
        rnd_rd = 0;
        read_chk("t1_pix23", 8'h23, 8'hE0);
        rnd_rd = 1;

        // 2: writes without commit across boundaries leave the display alone.
        for (int i = 0; i < 6; i++) begin
            write_px(8'($urandom), 8'($urandom), w);
            pwm_cycle_end = 1'b1; row_counter = 4'd15;
            cyc();
            pwm_cycle_end = 1'b0;
        end
        chk("t2_front", front_sel, 0);
        rnd_rd = 0;
        read_chk("t2_old_pix", 8'h23, 8'hE0);
        rnd_rd = 1;

        // 3: boundary on the commit cycle is skipped; mid-frame row pulses never swap.
        wr_if.wr_commit = 1'b1; pwm_cycle_end = 1'b1; row_counter = 4'd15;
        cyc();
        wr_if.wr_commit = 1'b0; pwm_cycle_end = 1'b0;
        chk("t3_busy", busy, 1);
        chk("t3_noswap", front_sel, 0);
        pwm_cycle_end = 1'b1; row_counter = 4'd7;
        idle(5);
        pwm_cycle_end = 1'b0;
        chk("t3_row7_front", front_sel, 0);
        chk("t3_row7_busy", busy, 1);
        wait_swap(40);
        chk("t3_front", front_sel, 1);

        // 4: clear with commit arriving mid-clear; whole new frame is the fill colour.
        pulse_clear(8'h1C);
        idle(9);
        pulse_commit();
        idle(245);
        chk("t4_still_clear_rdy", wr_if.wr_ready, 0);
        idle(1);
        chk("t4_swapwait_busy", busy, 1);
        chk("t4_swapwait_front", front_sel, 1);
        wait_swap(40);
        chk("t4_front", front_sel, 0);
        rnd_rd = 0;
        for (int i = 0; i < 256; i++) read_chk("t4_fill", 8'(i), 8'h1C);
        rnd_rd = 1;

        // 5: write held through a clear is accepted once when ready returns.
        cd = 8'($urandom);
        pulse_clear(cd);
        write_px(8'h5A, 8'hA5, w);
        chk("t5_wait_cycles", w, 257);
        pulse_commit();
        wait_swap(40);
        rnd_rd = 0;
        read_chk("t5_landed", 8'h5A, 8'hA5);
        read_chk("t5_neighbour", 8'h5B, cd);
        rnd_rd = 1;

        // Random traffic against the model.
        rnd_pwm = 1;
        for (int k = 0; k < 1500; k++) begin
            wr_if.wr_valid  = ($urandom_range(0, 1) == 1);
            wr_if.wr_addr   = 8'($urandom);
            wr_if.wr_data   = 8'($urandom);
            wr_if.wr_commit = ($urandom_range(0, 19) == 0);
            wr_if.clear_req = ($urandom_range(0, 149) == 0);
            wr_if.clear_data = 8'($urandom);
            cyc();
        end
        wr_if.wr_valid = 1'b0; wr_if.wr_commit = 1'b0; wr_if.clear_req = 1'b0;
        rnd_pwm = 0;
        row_counter = 4'd15;
        for (int k = 0; k < 600 && m_mode != 0; k++) begin
            pwm_cycle_end = (k % 4 == 3);
            cyc();
        end
        pwm_cycle_end = 1'b0;
        chk("pre_t6_idle", busy, 0);
        if (m_front == 0) begin
            pulse_commit();
            wait_swap(40);
        end

        // 6: reset in the middle of a clear aborts everything immediately.
        pulse_clear(8'h77);
        idle(50);
        #3 rst_n = 1'b0;
        #1;
        chk("t6_pixel", pixel_data, 8'h00);
        chk("t6_ready", wr_if.wr_ready, 0);
        chk("t6_busy", busy, 0);
        chk("t6_swap", swap_done, 0);
        chk("t6_front", front_sel, 0);
        model_reset();
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        cyc();
        chk("t6_ready_after", wr_if.wr_ready, 1);
        chk("t6_front_after", front_sel, 0);
        idle(20);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
